// File: rtl/ysyx_210238_pipe_ctrl_pkg.sv
// rtl/ysyx_210238_pipe_ctrl_pkg.sv - shared states, pc_sel codes and control-vector helpers for the pipeline controller
package ysyx_210238_pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_DRAIN     = 2'd1,
        ST_TRAP_WAIT = 2'd2
    } state_e;

    localparam logic [1:0] PC_SEQ  = 2'd0;
    localparam logic [1:0] PC_BR   = 2'd1;
    localparam logic [1:0] PC_TRAP = 2'd2;

    typedef struct packed {
        logic       hold_pc;
        logic       hold_if_id;
        logic       hold_id_ex;
        logic       hold_ex_mem;
        logic       hold_mem_wb;
        logic       clear_if_id;
        logic       clear_id_ex;
        logic       clear_ex_mem;
        logic       clear_mem_wb;
        logic [1:0] pc_sel;
        logic       fetch_kill;
    } ctrl_t;

    // Freeze everything up to EX/MEM and bubble MEM/WB while a data access is outstanding.
    function automatic ctrl_t ctrl_mem_stall();
        ctrl_t c;
        c              = '0;
        c.hold_pc      = 1'b1;
        c.hold_if_id   = 1'b1;
        c.hold_id_ex   = 1'b1;
        c.hold_ex_mem  = 1'b1;
        c.clear_mem_wb = 1'b1;
        return c;
    endfunction

    function automatic ctrl_t ctrl_trap_flush();
        ctrl_t c;
        c              = '0;
        c.clear_if_id  = 1'b1;
        c.clear_id_ex  = 1'b1;
        c.clear_ex_mem = 1'b1;
        c.clear_mem_wb = 1'b1;
        c.pc_sel       = PC_TRAP;
        return c;
    endfunction

    function automatic ctrl_t ctrl_reset();
        ctrl_t c;
        c              = '0;
        c.clear_if_id  = 1'b1;
        c.clear_id_ex  = 1'b1;
        c.clear_ex_mem = 1'b1;
        c.clear_mem_wb = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/ysyx_210238_pipe_ctrl_sat_cnt.sv
// rtl/ysyx_210238_pipe_ctrl_sat_cnt.sv - saturating event counter; EN=0 leaves no flops and drives zero
module ysyx_210238_sat_cnt #(
    parameter int W  = 32,
    parameter bit EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    generate
        if (EN) begin : g_cnt
            localparam logic [W-1:0] ONE = W'(1);
            logic [W-1:0] r_count;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_count <= '0;
                end else if (inc && (r_count != {W{1'b1}})) begin
                    r_count <= r_count + ONE;
                end
            end

            assign count = r_count;
        end else begin : g_tied
            logic w_unused;
            assign w_unused = ^{clk, rst_n, inc};
            assign count    = '0;
        end
    endgenerate

endmodule

// File: rtl/ysyx_210238_pipe_ctrl.sv
// rtl/ysyx_210238_pipe_ctrl.sv - 5-stage hazard/flush controller; YSYX_210238_PIPE_CTRL_PERF_EN enables the stall/flush counters
module ysyx_210238_pipe_ctrl
    import ysyx_210238_pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             if_busy,
    input  logic             mem_busy,
    input  logic             mdu_busy,
    input  logic             load_use,
    input  logic             br_redirect,
    input  logic             trap_req,
    output logic             hold_pc,
    output logic             hold_if_id,
    output logic             hold_id_ex,
    output logic             hold_ex_mem,
    output logic             hold_mem_wb,
    output logic             clear_if_id,
    output logic             clear_id_ex,
    output logic             clear_ex_mem,
    output logic             clear_mem_wb,
    output logic [1:0]       pc_sel,
    output logic             fetch_kill,
    output logic [CNT_W-1:0] cnt_stall,
    output logic [CNT_W-1:0] cnt_flush
);

`ifdef YSYX_210238_PIPE_CTRL_PERF_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    state_e r_state;
    state_e w_next;
    ctrl_t  w_dec;
    ctrl_t  w_ctrl;
    logic   w_br_act;
    logic   w_stall_inc;
    logic   w_flush_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_dec    = '0;
        w_next   = r_state;
        w_br_act = 1'b0;
        // A trap parked in TRAP_WAIT keeps acting even after trap_req drops.
        if (r_state == ST_TRAP_WAIT || trap_req) begin
            if (mem_busy) begin
                w_dec  = ctrl_mem_stall();
                w_next = ST_TRAP_WAIT;
            end else begin
                w_dec  = ctrl_trap_flush();
                w_next = if_busy ? ST_DRAIN : ST_RUN;
            end
        end else begin
            if (mem_busy) begin
                w_dec = ctrl_mem_stall();
            end else if (mdu_busy) begin
                w_dec.hold_pc      = 1'b1;
                w_dec.hold_if_id   = 1'b1;
                w_dec.hold_id_ex   = 1'b1;
                w_dec.clear_ex_mem = 1'b1;
            end else if (load_use) begin
                w_dec.hold_pc     = 1'b1;
                w_dec.hold_if_id  = 1'b1;
                w_dec.clear_id_ex = 1'b1;
            end else if (br_redirect) begin
                w_dec.clear_if_id = 1'b1;
                w_dec.clear_id_ex = 1'b1;
                w_dec.pc_sel      = PC_BR;
                w_br_act          = 1'b1;
            end else if (if_busy) begin
                w_dec.hold_pc     = 1'b1;
                w_dec.clear_if_id = 1'b1;
            end
            w_next = ((w_br_act || r_state == ST_DRAIN) && if_busy) ? ST_DRAIN : ST_RUN;
        end
        // The stale fetch still in flight is dropped; a redirect this cycle must still load the PC.
        if (r_state == ST_DRAIN) begin
            w_dec.fetch_kill  = 1'b1;
            w_dec.clear_if_id = 1'b1;
            if (if_busy && w_dec.pc_sel == PC_SEQ) begin
                w_dec.hold_pc = 1'b1;
            end
        end
        w_dec.hold_if_id  = w_dec.hold_if_id  & ~w_dec.clear_if_id;
        w_dec.hold_id_ex  = w_dec.hold_id_ex  & ~w_dec.clear_id_ex;
        w_dec.hold_ex_mem = w_dec.hold_ex_mem & ~w_dec.clear_ex_mem;
        w_dec.hold_mem_wb = w_dec.hold_mem_wb & ~w_dec.clear_mem_wb;
    end

    assign w_ctrl = rst_n ? w_dec : ctrl_reset();

    assign hold_pc      = w_ctrl.hold_pc;
    assign hold_if_id   = w_ctrl.hold_if_id;
    assign hold_id_ex   = w_ctrl.hold_id_ex;
    assign hold_ex_mem  = w_ctrl.hold_ex_mem;
    assign hold_mem_wb  = w_ctrl.hold_mem_wb;
    assign clear_if_id  = w_ctrl.clear_if_id;
    assign clear_id_ex  = w_ctrl.clear_id_ex;
    assign clear_ex_mem = w_ctrl.clear_ex_mem;
    assign clear_mem_wb = w_ctrl.clear_mem_wb;
    assign pc_sel       = w_ctrl.pc_sel;
    assign fetch_kill   = w_ctrl.fetch_kill;

    assign w_stall_inc = w_ctrl.hold_pc;
    assign w_flush_inc = w_ctrl.clear_if_id && (w_ctrl.pc_sel != PC_SEQ);

    ysyx_210238_sat_cnt #(.W(CNT_W), .EN(PERF_EN)) u_cnt_stall (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_stall_inc),
        .count (cnt_stall)
    );

    ysyx_210238_sat_cnt #(.W(CNT_W), .EN(PERF_EN)) u_cnt_flush (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_flush_inc),
        .count (cnt_flush)
    );

endmodule

// File: tb/tb_ysyx_210238_pipe_ctrl.sv
// tb/tb_ysyx_210238_pipe_ctrl.sv - directed plus randomized checks of the pipeline controller against a stage-index model
module tb_ysyx_210238_pipe_ctrl;

    localparam int TB_CNT_W = 4;
`ifdef YSYX_210238_PIPE_CTRL_PERF_EN
    localparam bit TB_PERF = 1'b1;
`else
    localparam bit TB_PERF = 1'b0;
`endif

    localparam int M_RUN = 0, M_DRAIN = 1, M_TW = 2;
    localparam logic [5:0] I_IF = 6'd1, I_MEM = 6'd2, I_MDU = 6'd4, I_LU = 6'd8, I_BR = 6'd16, I_TR = 6'd32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic if_busy = 1'b0, mem_busy = 1'b0, mdu_busy = 1'b0, load_use = 1'b0, br_redirect = 1'b0, trap_req = 1'b0;
    logic hold_pc, hold_if_id, hold_id_ex, hold_ex_mem, hold_mem_wb;
    logic clear_if_id, clear_id_ex, clear_ex_mem, clear_mem_wb;
    logic [1:0] pc_sel;
    logic fetch_kill;
    logic [TB_CNT_W-1:0] cnt_stall, cnt_flush;
    logic [11:0] w_vec;

    int n_cmp = 0;
    int n_bad = 0;
    int m_mode = M_RUN;
    int m_stall = 0;
    int m_flush = 0;

    ysyx_210238_pipe_ctrl #(.CNT_W(TB_CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .if_busy      (if_busy),
        .mem_busy     (mem_busy),
        .mdu_busy     (mdu_busy),
        .load_use     (load_use),
        .br_redirect  (br_redirect),
        .trap_req     (trap_req),
        .hold_pc      (hold_pc),
        .hold_if_id   (hold_if_id),
        .hold_id_ex   (hold_id_ex),
        .hold_ex_mem  (hold_ex_mem),
        .hold_mem_wb  (hold_mem_wb),
        .clear_if_id  (clear_if_id),
        .clear_id_ex  (clear_id_ex),
        .clear_ex_mem (clear_ex_mem),
        .clear_mem_wb (clear_mem_wb),
        .pc_sel       (pc_sel),
        .fetch_kill   (fetch_kill),
        .cnt_stall    (cnt_stall),
        .cnt_flush    (cnt_flush)
    );

    always #5 clk = ~clk;

    assign w_vec = {hold_pc, hold_if_id, hold_id_ex, hold_ex_mem, hold_mem_wb,
                    clear_if_id, clear_id_ex, clear_ex_mem, clear_mem_wb, pc_sel, fetch_kill};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Stage view: index 0 = PC, 1..4 = IF/ID..MEM/WB. A stall at stage k freezes everything
    // upstream of k and bubbles k; a flush clears a contiguous run of registers from IF/ID.
    function automatic void model(input int mode, input logic ifb, memb, mdub, lu, br, tr,
                                  output logic [11:0] v, output int nmode);
        logic [4:0] h;
        logic [4:0] c;
        int   ps;
        int   stall_at;
        logic kill;
        logic br_won;
        h = '0; c = '0; ps = 0; stall_at = -1; kill = 1'b0; br_won = 1'b0;
        if (mode == M_TW || tr) begin
            if (memb) begin
                stall_at = 4;
                nmode    = M_TW;
            end else begin
                c     = 5'b11110;
                ps    = 2;
                nmode = ifb ? M_DRAIN : M_RUN;
            end
        end else begin
            if (memb)      stall_at = 4;
            else if (mdub) stall_at = 3;
            else if (lu)   stall_at = 2;
            else if (br) begin
                c[1] = 1'b1; c[2] = 1'b1; ps = 1; br_won = 1'b1;
            end else if (ifb) stall_at = 1;
            nmode = ((br_won || mode == M_DRAIN) && ifb) ? M_DRAIN : M_RUN;
        end
        if (stall_at >= 0) begin
            for (int i = 0; i < stall_at; i++) h[i] = 1'b1;
            c[stall_at] = 1'b1;
        end
        if (mode == M_DRAIN) begin
            kill = 1'b1;
            c[1] = 1'b1;
            if (ps == 0 && ifb) h[0] = 1'b1;
        end
        for (int i = 1; i < 5; i++) if (c[i]) h[i] = 1'b0;
        v = {h[0], h[1], h[2], h[3], h[4], c[1], c[2], c[3], c[4], 2'(ps), kill};
    endfunction

    always @(negedge clk) begin
        logic [11:0] ev;
        int nm;
        if (!rst_n) begin
            check("model_rst_vec", {20'd0, w_vec}, 32'h078);
            check("model_rst_cnt", {24'd0, cnt_stall, cnt_flush}, 32'd0);
            m_mode  = M_RUN;
            m_stall = 0;
            m_flush = 0;
        end else begin
            model(m_mode, if_busy, mem_busy, mdu_busy, load_use, br_redirect, trap_req, ev, nm);
            check("model_ctrl", {20'd0, w_vec}, {20'd0, ev});
            check("model_cnt_stall", {28'd0, cnt_stall}, TB_PERF ? m_stall : 0);
            check("model_cnt_flush", {28'd0, cnt_flush}, TB_PERF ? m_flush : 0);
            if (ev[11] && m_stall < 15) m_stall++;
            if (ev[6] && ev[2:1] != 2'd0 && m_flush < 15) m_flush++;
            m_mode = nm;
        end
    end

    task automatic drive(input logic [5:0] in);
        @(posedge clk);
        #1;
        {trap_req, br_redirect, load_use, mdu_busy, mem_busy, if_busy} = in;
    endtask

    task automatic lit(input string name, input logic [11:0] exp);
        #2;
        check(name, {20'd0, w_vec}, {20'd0, exp});
    endtask

    initial begin
        #3;
        check("reset_outputs", {20'd0, w_vec}, {20'd0, 12'b00000_1111_00_0});
        @(posedge clk); #1; rst_n = 1'b1;

        drive(I_LU);         lit("load_use", 12'b11000_0100_00_0);
        drive(0);            lit("load_use_release", 12'b0);

        drive(I_BR | I_IF);  lit("br_c0", 12'b00000_1100_01_0);
        drive(I_IF);         lit("br_c1", 12'b10000_1000_00_1);
        drive(I_IF);         lit("br_c2", 12'b10000_1000_00_1);
        drive(0);            lit("br_c3", 12'b00000_1000_00_1);
        drive(0);            lit("br_c4", 12'b0);

        drive(I_TR | I_MEM); lit("trap_c0", 12'b11110_0001_00_0);
        for (int i = 1; i < 4; i++) begin
            drive(I_MEM);    lit("trap_wait", 12'b11110_0001_00_0);
        end
        drive(0);            lit("trap_c4", 12'b00000_1111_10_0);
        drive(0);            lit("trap_c5", 12'b0);

        drive(I_MEM | I_LU); lit("mem_over_lu", 12'b11110_0001_00_0);
        drive(0);

        drive(I_BR | I_IF);
        drive(I_IF);         lit("drain_pre_rst", 12'b10000_1000_00_1);
        #1; rst_n = 1'b0;
        #1; check("async_rst", {20'd0, w_vec}, {20'd0, 12'b00000_1111_00_0});
        @(posedge clk); #1; rst_n = 1'b1;
        lit("post_rst_run", 12'b10000_1000_00_0);

        @(posedge clk); #1; rst_n = 1'b0; if_busy = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive(I_LU);
            if (i == 10) begin
                #2; check("cnt_stall_mid", {28'd0, cnt_stall}, TB_PERF ? 32'd10 : 32'd0);
            end
        end
        drive(0);
        #2;
        check("cnt_stall_sat", {28'd0, cnt_stall}, TB_PERF ? 32'd15 : 32'd0);
        check("cnt_flush_idle", {28'd0, cnt_flush}, 32'd0);

        for (int n = 0; n < 3000; n++) begin
            @(posedge clk);
            #1;
            rst_n       = ($urandom_range(0, 149) != 0);
            if_busy     = ($urandom_range(0, 99) < 40);
            mem_busy    = ($urandom_range(0, 99) < 20);
            mdu_busy    = ($urandom_range(0, 99) < 15);
            load_use    = ($urandom_range(0, 99) < 15);
            br_redirect = ($urandom_range(0, 99) < 15);
            trap_req    = ($urandom_range(0, 99) < 8);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        {trap_req, br_redirect, load_use, mdu_busy, mem_busy, if_busy} = 6'd0;
        @(negedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
